// File: rtl/csr_feed_ctrl.sv
// Streams one IMAGE_SIZE x IMAGE_SIZE frame from pixel memory into a CSR encoder and
// collects its non-zero count. Optional WAIT watchdog: define CSR_FEED_TIMEOUT_EN.
module csr_feed_ctrl #(
  parameter int WORD_LENGTH = 8,
  parameter int IMAGE_SIZE  = 28,
  parameter int ADDR_WIDTH  = 10,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [WORD_LENGTH-1:0] mem_rd_data,
  output logic                   csr_rst,
  output logic                   csr_in_valid,
  output logic [WORD_LENGTH-1:0] csr_data_in,
  input  logic                   csr_out_valid,
  input  logic [COUNT_WIDTH-1:0] csr_valid_num,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] nnz_out,
  output logic                   error,
  output logic [2:0]             state_dbg
);

  localparam int PIXELS = IMAGE_SIZE * IMAGE_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);
  // An illegal configuration (address space too small, zero timeout) never leaves IDLE.
  localparam bit CFG_OK = (PIXELS <= (2 ** ADDR_WIDTH)) && (TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic                    abort_rst_q;
  logic                    abort_go;
  logic                    last_addr;
  logic                    wd_expired;

  assign abort_go  = abort && (state == S_CLR || state == S_STREAM || state == S_WAIT);
  assign last_addr = (addr_cnt == LAST_ADDR);
  assign state_dbg = state;
  assign mem_addr  = addr_cnt;
  // Data is forced to zero whenever no pixel is being presented.
  assign csr_data_in = csr_in_valid ? mem_rd_data : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort has priority over every forward transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !abort && CFG_OK) state_nxt = S_CLR;
      S_CLR:    state_nxt = abort ? S_IDLE : S_STREAM;
      S_STREAM: begin
        if (abort)          state_nxt = S_IDLE;
        else if (last_addr) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (abort)                            state_nxt = S_IDLE;
        else if (csr_out_valid || wd_expired) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_rd_en = (state == S_STREAM);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    csr_rst   = (state == S_CLR) || abort_rst_q;
  end

  // Datapath: address counter, read-to-present pipeline, abort clear pulse, result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt     <= '0;
      abort_rst_q  <= 1'b0;
      csr_in_valid <= 1'b0;
      nnz_out      <= '0;
    end else begin
      abort_rst_q  <= abort_go;
      csr_in_valid <= mem_rd_en && !abort;
      if (state == S_CLR || abort_go)
        addr_cnt <= '0;
      else if (state == S_STREAM)
        addr_cnt <= last_addr ? '0 : addr_cnt + ADDR_WIDTH'(1);
      if (state == S_WAIT && !abort) begin
        if (csr_out_valid)   nnz_out <= csr_valid_num;
        else if (wd_expired) nnz_out <= '0;
      end
    end
  end

`ifdef CSR_FEED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            error_q;

  // Fires on the last allowed WAIT cycle so DONE follows exactly TIMEOUT WAIT cycles.
  assign wd_expired = (state == S_WAIT) && !csr_out_valid && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign error      = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else if (state == S_CLR) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_expired && !abort) error_q <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_csr_feed_ctrl.sv
// Bench for csr_feed_ctrl: pixel memory + encoder models, stream monitor, vector table,
// corner-case sequences and randomized frames against a frame-level reference model.
module tb_csr_feed_ctrl;

  localparam int WL = 8;
  localparam int IS = 4;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int TO = 8;
  localparam int N  = IS * IS;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [WL-1:0] mem_rd_data;
  logic          csr_rst, csr_in_valid;
  logic [WL-1:0] csr_data_in;
  logic          csr_out_valid;
  logic [CW-1:0] csr_valid_num;
  logic          busy, done, error;
  logic [CW-1:0] nnz_out;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  csr_feed_ctrl #(
    .WORD_LENGTH(WL), .IMAGE_SIZE(IS), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .csr_rst(csr_rst), .csr_in_valid(csr_in_valid), .csr_data_in(csr_data_in),
    .csr_out_valid(csr_out_valid), .csr_valid_num(csr_valid_num),
    .busy(busy), .done(done), .nnz_out(nnz_out), .error(error), .state_dbg(state_dbg)
  );

  // Clock / global time limit
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pixel memory: one-cycle read latency
  logic [WL-1:0] image [N];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= image[mem_addr[3:0]];

  // Encoder model: counts non-zero pixels, raises out_valid enc_dly cycles after
  // the last pixel (0 = never), cleared by csr_rst or reset.
  int enc_dly_cfg;
  int enc_seen, enc_tmr;
  logic [CW-1:0] enc_cnt;
  logic enc_ov;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || csr_rst) begin
      enc_seen <= 0; enc_tmr <= 0; enc_cnt <= '0; enc_ov <= 1'b0;
    end else begin
      if (csr_in_valid) begin
        enc_seen <= enc_seen + 1;
        if (csr_data_in != '0) enc_cnt <= enc_cnt + 1'b1;
        if (enc_seen == N - 1) begin
          if (enc_dly_cfg == 1)     enc_ov  <= 1'b1;
          else if (enc_dly_cfg > 1) enc_tmr <= enc_dly_cfg - 1;
        end
      end
      if (enc_tmr != 0) begin
        enc_tmr <= enc_tmr - 1;
        if (enc_tmr == 1) enc_ov <= 1'b1;
      end
    end
  end
  assign csr_out_valid = enc_ov;
  assign csr_valid_num = enc_cnt;

  // Stream monitor: in-order gapless addresses, valid = delayed read, data = memory word
  int   exp_addr = 0;
  int   pix_cnt  = 0;
  logic last_rd_en = 1'b0, last_abort = 1'b0, last_rst_n = 1'b0;
  logic [AW-1:0] last_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_addr = 0;
      pix_cnt  = 0;
    end else begin
      if (last_rst_n)
        chk("in_valid_follows_rd_en", csr_in_valid, last_rd_en && !last_abort);
      if (csr_in_valid) begin
        chk("pixel_data", csr_data_in, image[last_addr[3:0]]);
        pix_cnt++;
      end
      if (mem_rd_en) begin
        chk("mem_addr_seq", mem_addr, exp_addr);
        exp_addr++;
      end
      if (done) chk("pixels_per_frame", pix_cnt, N);
      if (csr_rst) begin
        exp_addr = 0;
        pix_cnt  = 0;
      end
    end
    last_rd_en = mem_rd_en;
    last_addr  = mem_addr;
    last_abort = abort;
    last_rst_n = rst_n;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_image(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       image[i] = '0;
        1:       image[i] = (i == 0 || i == 3 || i == 7 || i == 11 || i == 15) ? WL'(i + 1) : '0;
        default: image[i] = WL'(i + 1);
      endcase
    end
  endtask

  // Counts cycles from lat0 until done is seen; lat is the cycle index of the done cycle.
  task automatic wait_done(input int lat0, output int lat);
    bit found = 0;
    lat = lat0;
    while (!found && lat < 300) begin
      tick();
      lat++;
      if (done) found = 1;
    end
    chk("done_seen", found, 1);
  endtask

  task automatic run_frame(input int dly, input bit hold, output int lat);
    enc_dly_cfg = dly;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    if (done) chk("early_done", done, 0);
    wait_done(1, lat);
  endtask

  function automatic int ref_nnz();
    int c = 0;
    for (int i = 0; i < N; i++) if (image[i] != '0) c++;
    return c;
  endfunction

  typedef struct {
    int mode;
    int dly;
    int exp_nnz;
    int exp_lat;
  } vec_t;

  vec_t vecs[5];
  int   lat, lat2, prev_nnz, dly;

  initial begin
    vecs[0] = '{1, 1, 5, 20};
    vecs[1] = '{0, 1, 0, 20};
    vecs[2] = '{2, 2, 16, 21};
    vecs[3] = '{1, 4, 5, 23};
    vecs[4] = '{2, 6, 16, 25};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; enc_dly_cfg = 1;
    fill_image(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state_dbg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_csr_rst", csr_rst, 0);
    chk("rst_in_valid", csr_in_valid, 0);
    chk("rst_data", csr_data_in, 0);
    chk("rst_nnz", nnz_out, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven frames; abort during the DONE cycle of vector 3 must be ignored
    for (int v = 0; v < 5; v++) begin
      fill_image(vecs[v].mode);
      run_frame(vecs[v].dly, 1'b0, lat);
      chk("vec_latency", lat, vecs[v].exp_lat);
      chk("vec_nnz", nnz_out, vecs[v].exp_nnz);
      chk("vec_done_busy", busy, 1);
      chk("vec_error", error, 0);
      abort = (v == 3);
      tick();
      abort = 1'b0;
      chk("vec_done_pulse", done, 0);
      chk("vec_busy_falls", busy, 0);
      chk("vec_no_abort_rst", csr_rst, 0);
      chk("vec_nnz_hold", nnz_out, vecs[v].exp_nnz);
      prev_nnz = vecs[v].exp_nnz;
    end

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_csr_rst", csr_rst, 0);
    end
    start = 1'b0; abort = 1'b0;
    tick();

    // Abort at STREAM address 7
    fill_image(2);
    enc_dly_cfg = 1;
    start = 1'b1;
    lat = 0;
    while (!(mem_rd_en && mem_addr == 7) && lat < 40) begin
      tick();
      start = 1'b0;
      lat++;
    end
    chk("reach_addr7", mem_addr, 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_csr_rst", csr_rst, 1);
    chk("abort_no_done", done, 0);
    chk("abort_nnz_kept", nnz_out, prev_nnz);
    tick();
    chk("abort_rst_one_cycle", csr_rst, 0);
    repeat (25) begin
      tick();
      if (done) chk("abort_spurious_done", done, 0);
    end

    // Abort in WAIT (encoder never finishes): cycles 1 CLR, 2..17 STREAM, 18 WAIT
    fill_image(1);
    enc_dly_cfg = 0;
    start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tick();
      start = 1'b0;
    end
    chk("wait_reached", busy && !mem_rd_en && !csr_rst, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wait_abort_busy", busy, 0);
    chk("wait_abort_csr_rst", csr_rst, 1);
    chk("wait_abort_nnz", nnz_out, prev_nnz);
    tick();

    // Back-to-back with start held high
    fill_image(1);
    run_frame(1, 1'b1, lat);
    chk("b2b_first_latency", lat, 20);
    chk("b2b_first_nnz", nnz_out, 5);
    fill_image(2);
    tick();
    chk("b2b_gap_idle", busy, 0);
    chk("b2b_gap_no_rst", csr_rst, 0);
    tick();
    chk("b2b_second_clr", csr_rst, 1);
    chk("b2b_second_busy", busy, 1);
    start = 1'b0;
    wait_done(1, lat2);
    chk("b2b_second_latency", lat2, 20);
    chk("b2b_second_nnz", nnz_out, 16);
    tick();

    // Reset pulse while in WAIT, then a full frame
    fill_image(1);
    enc_dly_cfg = 0;
    start = 1'b1;
    for (int c = 0; c < 19; c++) begin
      tick();
      start = 1'b0;
    end
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outputs", {mem_rd_en, csr_in_valid, csr_rst, done, error}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_data", csr_data_in, 0);
    chk("mid_rst_nnz", nnz_out, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_csr_rst", csr_rst, 0);
    run_frame(1, 1'b0, lat);
    chk("post_rst_latency", lat, 20);
    chk("post_rst_nnz", nnz_out, 5);
    tick();

`ifdef CSR_FEED_TIMEOUT_EN
    // Watchdog: encoder never answers
    fill_image(2);
    run_frame(0, 1'b0, lat);
    chk("wd_latency", lat, 1 + N + TO + 1);
    chk("wd_error", error, 1);
    chk("wd_nnz", nnz_out, 0);
    tick();
    chk("wd_error_sticky", error, 1);
    run_frame(1, 1'b0, lat);
    chk("wd_cleared_error", error, 0);
    chk("wd_next_nnz", nnz_out, 16);
    tick();
`endif

    // Randomized frames against the frame-level reference model
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++)
        image[i] = ($urandom_range(0, 1) == 1) ? WL'($urandom_range(1, 255)) : '0;
      dly = $urandom_range(1, 6);
      run_frame(dly, 1'b0, lat);
      chk("rand_latency", lat, 1 + N + (dly + 1) + 1);
      chk("rand_nnz", nnz_out, ref_nnz());
      chk("rand_error", error, 0);
      repeat ($urandom_range(1, 3)) tick();
      chk("rand_idle", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_feed_ctrl.md
CSR_FEED_CTRL -- requirements
Module: csr_feed_ctrl

Interface
REQ-001 Parameter WORD_LENGTH, default 8, pixel width in bits.
REQ-002 Parameter IMAGE_SIZE, default 28, image edge length; frame = IMAGE_SIZE*IMAGE_SIZE pixels.
REQ-003 Parameter ADDR_WIDTH, default 10, pixel-memory address width; SHALL satisfy 2**ADDR_WIDTH >= IMAGE_SIZE*IMAGE_SIZE.
REQ-004 Parameter COUNT_WIDTH, default 16, width of the non-zero count.
REQ-005 Parameter TIMEOUT, default 64, watchdog limit in cycles for the WAIT state.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request to encode one frame; sampled in IDLE only.
REQ-009 abort  input  1  synchronous abort of the frame in progress.
REQ-010 mem_rd_en  output  1  pixel-memory read strobe.
REQ-011 mem_addr  output  ADDR_WIDTH  pixel read address, row-major.
REQ-012 mem_rd_data  input  WORD_LENGTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 csr_rst  output  1  active-high synchronous clear pulse to the CSR encoder.
REQ-014 csr_in_valid  output  1  pixel-valid strobe to the encoder.
REQ-015 csr_data_in  output  WORD_LENGTH  pixel to the encoder.
REQ-016 csr_out_valid  input  1  encoder done flag (level).
REQ-017 csr_valid_num  input  COUNT_WIDTH  encoder non-zero count.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle completion pulse.
REQ-020 nnz_out  output  COUNT_WIDTH  non-zero count latched at completion.
REQ-021 error  output  1  sticky watchdog flag.

Function
REQ-022 States SHALL be IDLE, CLR, STREAM, WAIT, DONE.
REQ-023 IDLE: start=1 with abort=0 SHALL move to CLR; all other inputs are ignored.
REQ-024 CLR: SHALL assert csr_rst for exactly one cycle, clear the address counter and the watchdog counter, clear error, then move to STREAM.
REQ-025 STREAM: SHALL assert mem_rd_en every cycle, with mem_addr running 0..IMAGE_SIZE*IMAGE_SIZE-1 in order, one address per cycle and no gaps.
REQ-026 csr_in_valid SHALL be mem_rd_en delayed by one cycle, with csr_data_in = mem_rd_data in that cycle; frame pixels are presented on exactly IMAGE_SIZE*IMAGE_SIZE consecutive cycles.
REQ-027 After issuing the last address, the controller SHALL move to WAIT; the final csr_in_valid occurs in the first WAIT cycle.
REQ-028 WAIT: on csr_out_valid=1 the controller SHALL latch csr_valid_num into nnz_out and move to DONE.
REQ-029 DONE: done SHALL be high for exactly this one cycle, then the controller returns to IDLE.
REQ-030 Latency: done SHALL rise 1 (CLR) + IMAGE_SIZE*IMAGE_SIZE + k + 1 cycles after start is sampled, where k is the number of WAIT cycles.
REQ-031 abort=1 in CLR, STREAM or WAIT SHALL, on the next edge: enter IDLE, deassert mem_rd_en, cancel any pending csr_in_valid, pulse csr_rst for one cycle, keep nnz_out unchanged and not pulse done.
REQ-032 abort in IDLE or DONE SHALL have no effect; a DONE cycle completes normally.
REQ-033 start and abort high together in IDLE: abort wins and the controller stays in IDLE.
REQ-034 start held high through DONE SHALL begin a new frame only from the following IDLE cycle, giving a 1-cycle minimum gap between frames.
REQ-035 Address and count arithmetic SHALL be unsigned and sized to never wrap within a frame.

Reset
REQ-036 While rst_n=0: state=IDLE; mem_rd_en, csr_in_valid, csr_rst, busy, done, error = 0; mem_addr, csr_data_in, nnz_out = 0; all counters = 0.
REQ-037 rst_n asserted mid-frame SHALL abandon the frame without a csr_rst pulse; the encoder shares the same reset.

Configuration
REQ-038 Macro CSR_FEED_TIMEOUT_EN defined: the watchdog counts WAIT cycles. If TIMEOUT cycles pass without csr_out_valid, it SHALL set error=1, pulse done with nnz_out=0, and return to IDLE via DONE. error stays set until the next CLR or reset.
REQ-039 Macro undefined: no watchdog logic is built, WAIT lasts indefinitely, and error is tied to 0.

Verification
REQ-040 IMAGE_SIZE=4, 16 pixels with 5 non-zero, encoder model raises out_valid 2 cycles after the last pixel -> addresses 0..15 contiguous, done 1+16+2+1=20 cycles after start, nnz_out=5.
REQ-041 All-zero frame -> nnz_out=0, done pulses once, busy falls the cycle after done.
REQ-042 abort at STREAM address 7 -> next cycle IDLE, mem_rd_en=0, csr_rst pulse, no done, nnz_out keeps previous value.
REQ-043 Back-to-back: start held high -> second CLR one cycle after the first done; both frames give correct counts.
REQ-044 CSR_FEED_TIMEOUT_EN, TIMEOUT=8, out_valid never rises -> error=1 and done after 8 WAIT cycles, nnz_out=0; next start clears error.
REQ-045 rst_n low for 1 cycle in WAIT -> all outputs at reset values; a new start then runs a full frame correctly.
